// File: rtl/plot_sink_if.sv
// plot_sink_if
// Bundles the pixel-write stream from the draw manager, the clear command,
// the status flags and the framebuffer write port of plot_sink.
//   plot/x/y/colour : pixel write request (x 0..159, y 0..119, {R,G,B})
//   clear           : start a full-screen clear sweep
//   mem_wait        : framebuffer busy, hold off new writes
//   ready/busy      : can accept a plot / clear sweep in progress
//   overflow        : sticky, plot seen while not ready
//   range_err       : sticky, accepted plot was off-screen
//   mem_addr/mem_data/mem_we : framebuffer write port (one-cycle strobe)
// Modports: master = upstream/test driver, slave = plot_sink.
interface plot_sink_if;
   logic        plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        clear;
   logic        mem_wait;
   logic        ready;
   logic        busy;
   logic        overflow;
   logic        range_err;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_we;

   modport master (
      output plot, x, y, colour, clear, mem_wait,
      input  ready, busy, overflow, range_err, mem_addr, mem_data, mem_we
   );

   modport slave (
      input  plot, x, y, colour, clear, mem_wait,
      output ready, busy, overflow, range_err, mem_addr, mem_data, mem_we
   );
endinterface

// File: rtl/plot_sink.sv
// plot_sink
// Pixel-write receiver for the 160x120 3-bit display. Plots are converted to
// a linear address y*160+x at push time, buffered in a small FIFO and retired
// as single-cycle writes to the framebuffer. A clear command flushes the FIFO
// and sweeps every address 0..19199 with CLEAR_COLOUR.
// Ports:
//   clk50  : 50 MHz system clock
//   resetn : asynchronous active-low reset
//   bus    : plot_sink_if.slave (pixel stream, clear, flags, memory port)
// Parameters:
//   FIFO_DEPTH   : buffered plot entries (power of two, >= 2)
//   CLEAR_COLOUR : colour written by the clear sweep
module plot_sink #(
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [2:0] CLEAR_COLOUR = 3'b001
) (
   input  logic         clk50,
   input  logic         resetn,
   plot_sink_if.slave   bus
);

   localparam int          PTR_W     = $clog2(FIFO_DEPTH);
   localparam int          CNT_W     = PTR_W + 1;
   localparam logic [14:0] LAST_ADDR = 15'd19199;

   typedef enum logic {RUN, CLEAR} state_t;

   state_t             state_reg;
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [14:0]        sweep_reg;
   logic               busy_reg;
   logic               overflow_reg;
   logic               range_err_reg;
   logic [14:0]        mem_addr_reg;
   logic [2:0]         mem_data_reg;
   logic               mem_we_reg;

   // FIFO storage; no reset so it maps onto distributed/block RAM
   logic [14:0]        addr_mem   [FIFO_DEPTH];
   logic [2:0]         colour_mem [FIFO_DEPTH];

   logic               ready_int;
   logic               in_range;
   logic               push;
   logic               pop;
   logic [14:0]        push_addr;

   assign ready_int = (state_reg == RUN) && (count_reg < CNT_W'(FIFO_DEPTH));
   assign in_range  = (bus.x < 8'd160) && (bus.y < 7'd120);

   // y*160 = y*128 + y*32, done with shifts in 15 bits
   assign push_addr = ({8'd0, bus.y} << 7) + ({8'd0, bus.y} << 5) + {7'd0, bus.x};

   // A clear in RUN wins over both push and pop: everything pending is dropped
   assign push = bus.plot && ready_int && in_range && !bus.clear;
   assign pop  = (state_reg == RUN) && (count_reg != '0) && !bus.mem_wait && !bus.clear;

   always_ff @(posedge clk50) begin
      if (push) begin
         addr_mem[wr_ptr_reg]   <= push_addr;
         colour_mem[wr_ptr_reg] <= bus.colour;
      end
   end

   always_ff @(posedge clk50 or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= RUN;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         sweep_reg     <= '0;
         busy_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         range_err_reg <= 1'b0;
         mem_addr_reg  <= '0;
         mem_data_reg  <= '0;
         mem_we_reg    <= 1'b0;
      end else begin
         mem_we_reg <= 1'b0;

         if (bus.plot && !ready_int)
            overflow_reg <= 1'b1;
         if (bus.plot && ready_int && !in_range)
            range_err_reg <= 1'b1;

         case (state_reg)
            RUN: begin
               if (bus.clear) begin
                  state_reg  <= CLEAR;
                  wr_ptr_reg <= '0;
                  rd_ptr_reg <= '0;
                  count_reg  <= '0;
                  sweep_reg  <= '0;
                  busy_reg   <= 1'b1;
               end else begin
                  if (push)
                     wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                  if (pop) begin
                     rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                     mem_addr_reg <= addr_mem[rd_ptr_reg];
                     mem_data_reg <= colour_mem[rd_ptr_reg];
                     mem_we_reg   <= 1'b1;
                  end
                  case ({push, pop})
                     2'b10:   count_reg <= count_reg + CNT_W'(1);
                     2'b01:   count_reg <= count_reg - CNT_W'(1);
                     default: count_reg <= count_reg;
                  endcase
               end
            end
            CLEAR: begin
               if (bus.clear) begin
                  // Re-issued clear restarts the sweep from the top
                  sweep_reg <= '0;
               end else if (!bus.mem_wait) begin
                  mem_addr_reg <= sweep_reg;
                  mem_data_reg <= CLEAR_COLOUR;
                  mem_we_reg   <= 1'b1;
                  if (sweep_reg == LAST_ADDR) begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b0;
                     sweep_reg <= '0;
                  end else begin
                     sweep_reg <= sweep_reg + 15'd1;
                  end
               end
            end
            default: state_reg <= RUN;
         endcase
      end
   end

   assign bus.ready     = ready_int;
   assign bus.busy      = busy_reg;
   assign bus.overflow  = overflow_reg;
   assign bus.range_err = range_err_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_data  = mem_data_reg;
   assign bus.mem_we    = mem_we_reg;

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink
// Directed test of plot_sink: reset values, single-pixel latency, sustained
// burst, off-screen rejection, back-pressure/overflow, full clear sweep and
// reset during a sweep. Inputs change and outputs are sampled on the falling
// edge of clk50.
module tb_plot_sink;

   logic clk50 = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #10 clk50 = ~clk50;

   plot_sink_if bus ();

   plot_sink #(
      .FIFO_DEPTH   (4),
      .CLEAR_COLOUR (3'b001)
   ) dut (
      .clk50  (clk50),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk50);
   endtask

   task automatic drive(input logic p, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] c);
      bus.plot   = p;
      bus.x      = xx;
      bus.y      = yy;
      bus.colour = c;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad_wr;
      int bad_flag;

      drive(1'b0, 8'd0, 7'd0, 3'd0);
      bus.clear    = 1'b0;
      bus.mem_wait = 1'b0;

      // ---- reset values ----
      tick(); tick();
      check("rst_mem_we",    bus.mem_we, 0);
      check("rst_mem_addr",  bus.mem_addr, 0);
      check("rst_mem_data",  bus.mem_data, 0);
      check("rst_busy",      bus.busy, 0);
      check("rst_overflow",  bus.overflow, 0);
      check("rst_range_err", bus.range_err, 0);
      resetn = 1'b1;
      tick();
      check("rst_ready", bus.ready, 1);
      $display("step reset: done");

      // ---- single plot (5,3) -> 3*160+5 = 485, two-cycle latency ----
      drive(1'b1, 8'd5, 7'd3, 3'b010);
      tick();
      drive(1'b0, 8'd0, 7'd0, 3'd0);
      check("single_we_early", bus.mem_we, 0);
      tick();
      check("single_we",   bus.mem_we, 1);
      check("single_addr", bus.mem_addr, 485);
      check("single_data", bus.mem_data, 3'b010);
      tick();
      check("single_we_drop",   bus.mem_we, 0);
      check("single_overflow",  bus.overflow, 0);
      check("single_range_err", bus.range_err, 0);
      $display("step single plot: addr=%0d", 485);

      // ---- 10 back-to-back plots on row 119 -> 19040..19049 ----
      for (int i = 0; i <= 12; i++) begin
         check($sformatf("burst_ready_%0d", i), bus.ready, 1);
         if (i >= 2 && i <= 11) begin
            check($sformatf("burst_we_%0d", i), bus.mem_we, 1);
            check($sformatf("burst_addr_%0d", i), bus.mem_addr, 19040 + i - 2);
            check($sformatf("burst_data_%0d", i), bus.mem_data, (i - 2) % 8);
         end else begin
            check($sformatf("burst_idle_%0d", i), bus.mem_we, 0);
         end
         if (i < 10) drive(1'b1, 8'(i), 7'd119, 3'((i) % 8));
         else        drive(1'b0, 8'd0, 7'd0, 3'd0);
         tick();
      end
      $display("step burst: 10 writes 19040..19049");

      // ---- off-screen plots are dropped ----
      drive(1'b1, 8'd160, 7'd0, 3'd7);
      tick();
      drive(1'b1, 8'd0, 7'd120, 3'd7);
      tick();
      drive(1'b0, 8'd0, 7'd0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("range_no_we_%0d", i), bus.mem_we, 0);
         tick();
      end
      check("range_err_set", bus.range_err, 1);
      check("range_no_ovf",  bus.overflow, 0);
      $display("step range: range_err=%0d", bus.range_err);

      // ---- back-pressure: 6 plots into a 4-deep FIFO ----
      bus.mem_wait = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bp_ready_%0d", i), bus.ready, (i < 4) ? 1 : 0);
         check($sformatf("bp_no_we_%0d", i), bus.mem_we, 0);
         drive(1'b1, 8'(10 + i), 7'd1, 3'(4 + i));
         tick();
      end
      drive(1'b0, 8'd0, 7'd0, 3'd0);
      check("bp_overflow", bus.overflow, 1);
      check("bp_full_ready", bus.ready, 0);
      bus.mem_wait = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_we_%0d", i), bus.mem_we, 1);
         check($sformatf("bp_addr_%0d", i), bus.mem_addr, 160 + 10 + i);
         check($sformatf("bp_data_%0d", i), bus.mem_data, 4 + i);
         check($sformatf("bp_ready_after_%0d", i), bus.ready, 1);
         tick();
      end
      check("bp_drained", bus.mem_we, 0);
      $display("step backpressure: 4 writes, overflow=%0d", bus.overflow);

      // ---- clear with two entries pending ----
      bus.mem_wait = 1'b1;
      drive(1'b1, 8'd50, 7'd50, 3'd6);
      tick();
      drive(1'b1, 8'd51, 7'd50, 3'd6);
      tick();
      drive(1'b0, 8'd0, 7'd0, 3'd0);
      bus.clear = 1'b1;
      tick();
      bus.clear    = 1'b0;
      bus.mem_wait = 1'b0;
      check("clr_busy_start",  bus.busy, 1);
      check("clr_ready_start", bus.ready, 0);
      check("clr_no_pending",  bus.mem_we, 0);
      tick();
      bad_wr   = 0;
      bad_flag = 0;
      for (int j = 0; j < 19199; j++) begin
         if (!(bus.mem_we === 1'b1 && bus.mem_addr === 15'(j) && bus.mem_data === 3'b001))
            bad_wr++;
         if (!(bus.busy === 1'b1 && bus.ready === 1'b0))
            bad_flag++;
         tick();
      end
      check("clr_bad_writes", bad_wr, 0);
      check("clr_bad_flags",  bad_flag, 0);
      check("clr_last_we",    bus.mem_we, 1);
      check("clr_last_addr",  bus.mem_addr, 19199);
      check("clr_last_data",  bus.mem_data, 3'b001);
      check("clr_end_busy",   bus.busy, 0);
      check("clr_end_ready",  bus.ready, 1);
      tick();
      check("clr_after_no_we", bus.mem_we, 0);
      $display("step clear: 19200 writes, bad=%0d", bad_wr);

      // ---- reset in the middle of a sweep ----
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      for (int j = 0; j < 1000; j++) tick();
      check("mid_we",   bus.mem_we, 1);
      check("mid_addr", bus.mem_addr, 999);
      check("mid_busy", bus.busy, 1);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_we",        bus.mem_we, 0);
      check("mid_rst_busy",      bus.busy, 0);
      check("mid_rst_overflow",  bus.overflow, 0);
      check("mid_rst_range_err", bus.range_err, 0);
      check("mid_rst_addr",      bus.mem_addr, 0);
      tick(); tick();
      resetn = 1'b1;
      tick();
      check("post_rst_ready", bus.ready, 1);
      check("post_rst_idle",  bus.mem_we, 0);
      drive(1'b1, 8'd7, 7'd2, 3'd5);
      tick();
      drive(1'b0, 8'd0, 7'd0, 3'd0);
      check("post_rst_we_early", bus.mem_we, 0);
      tick();
      check("post_rst_we",   bus.mem_we, 1);
      check("post_rst_addr", bus.mem_addr, 327);
      check("post_rst_data", bus.mem_data, 5);
      tick();
      check("post_rst_we_drop", bus.mem_we, 0);
      $display("step reset mid-sweep: plot addr=%0d", 327);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
